// File: rtl/vram_frame_writer.sv
// vram_frame_writer: packs 2-bit pixels into VRAM bytes and writes them to a rectangular framebuffer window
module vram_frame_writer #(
  parameter int ROW_BYTES = 48,
  parameter int ROWS = 170,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce,
  input  logic              start,
  input  logic [5:0]        x_start,
  input  logic [7:0]        y_start,
  input  logic [7:0]        width_px,
  input  logic [7:0]        height,
  input  logic              pix_valid,
  input  logic [1:0]        pix_data,
  output logic              pix_ready,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_wdata,
  output logic              vram_we,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, ACCUM, WRITE, DONE} state_t;
  localparam logic [5:0] LAST_COL = 6'(ROW_BYTES - 1);
  localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);
  localparam logic [ADDR_W-1:0] RB = ADDR_W'(ROW_BYTES);
  state_t state, state_n;
  logic [7:0] row, rowpix, rowcnt, w, h, sh, sh_n;
  logic [5:0] col, x0;
  logic [1:0] slot;
  logic xfer, last, eor;
  always_comb begin
    pix_ready = ce && state == ACCUM;
    vram_we = ce && state == WRITE;
    done = ce && state == DONE;
    busy = state != IDLE;
    xfer = pix_ready && pix_valid;
    sh_n = sh | (8'(pix_data) << {slot, 1'b0});
    last = slot == 2'd3 || rowpix + 8'd1 == w;
    eor = rowpix == w;
    state_n = state;
    if (ce)
      case (state)
        IDLE:  state_n = !start ? IDLE : (width_px == 8'd0 || height == 8'd0) ? DONE : ACCUM;
        ACCUM: state_n = (xfer && last) ? WRITE : ACCUM;
        WRITE: state_n = (eor && rowcnt + 8'd1 == h) ? DONE : ACCUM;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
      slot <= '0;
      rowpix <= '0;
      rowcnt <= '0;
      sh <= '0;
      x0 <= '0;
      w <= '0;
      h <= '0;
      vram_addr <= '0;
      vram_wdata <= '0;
    end else if (ce) begin
      state <= state_n;
      if (state == IDLE && start) begin
        x0 <= x_start;
        w <= width_px;
        h <= height;
        row <= y_start;
        col <= x_start;
        slot <= '0;
        rowpix <= '0;
        rowcnt <= '0;
        sh <= '0;
      end
      if (xfer) begin
        sh <= sh_n;
        slot <= slot + 2'd1;
        rowpix <= rowpix + 8'd1;
        // address and data are captured with the completing pixel so they are valid throughout WRITE
        if (last) begin
          vram_addr <= ADDR_W'(row) * RB + ADDR_W'(col);
          vram_wdata <= sh_n;
        end
      end
      if (state == WRITE) begin
        sh <= '0;
        slot <= '0;
        col <= col == LAST_COL ? 6'd0 : col + 6'd1;
        if (eor) begin
          row <= row == LAST_ROW ? 8'd0 : row + 8'd1;
          col <= x0;
          rowpix <= '0;
          rowcnt <= rowcnt + 8'd1;
        end
      end
    end
endmodule

// File: tb/tb_vram_frame_writer.sv
// tb_vram_frame_writer: directed self-checking bench for vram_frame_writer
module tb_vram_frame_writer;
  logic clk = 0, reset_n = 0, ce = 0, start = 0, pix_valid = 0;
  logic [5:0] x_start = 0;
  logic [7:0] y_start = 0, width_px = 0, height = 0;
  logic [1:0] pix_data = 0;
  logic pix_ready, vram_we, busy, done;
  logic [12:0] vram_addr;
  logic [7:0] vram_wdata;
  int total = 0, bad = 0, xfer_cnt = 0, done_cnt = 0;
  logic [12:0] wa[$], ea[$];
  logic [7:0] wd[$], ed[$];
  logic [1:0] pq[$];

  vram_frame_writer dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .start(start),
    .x_start(x_start), .y_start(y_start), .width_px(width_px), .height(height),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (vram_we) begin
      wa.push_back(vram_addr);
      wd.push_back(vram_wdata);
    end
    if (pix_ready && pix_valid) xfer_cnt++;
    if (done) done_cnt++;
    if (!ce) begin
      total++;
      assert ({vram_we, pix_ready, done} === 3'b000)
      else begin
        bad++;
        $error("FAIL ce0_quiet we/rdy/done=%b expected 000", {vram_we, pix_ready, done});
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear();
    wa.delete(); wd.delete(); ea.delete(); ed.delete(); pq.delete();
  endtask

  task automatic start_win(input int x, input int y, input int w, input int h);
    x_start = 6'(x); y_start = 8'(y); width_px = 8'(w); height = 8'(h);
    ce = 1; start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic feed(input bit stall);
    int i = 0, g = 0;
    bit took;
    while (i < pq.size() && g < 3000) begin
      pix_data = pq[i];
      pix_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      ce = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      took = pix_ready && pix_valid;
      @(posedge clk); #1;
      if (took) i++;
      g++;
    end
    pix_valid = 0;
    ce = 1;
    chk("feed_count", i, pq.size());
  endtask

  task automatic wait_done(input string tag, input int d0);
    int g = 0;
    ce = 1;
    while (done_cnt == d0 && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    @(posedge clk); #1;
    chk({tag, "_done"}, done_cnt, d0 + 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwr"}, wa.size(), ea.size());
    for (int i = 0; i < ea.size(); i++)
      if (i < wa.size()) begin
        chk({tag, "_addr"}, wa[i], ea[i]);
        chk({tag, "_data"}, wd[i], ed[i]);
      end
  endtask

  initial begin
    int d0, x0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", vram_we, 0);
    chk("rst_addr", vram_addr, 0);
    chk("rst_data", vram_wdata, 0);
    reset_n = 1;
    @(posedge clk); #1;

    clear();
    pq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd3, 2'd3, 2'd3};
    ea = '{13'h0000, 13'h0001}; ed = '{8'h39, 8'hFF};
    d0 = done_cnt;
    start_win(0, 0, 8, 1);
    chk("t1_busy_on", busy, 1);
    feed(0);
    wait_done("t1", d0);
    check_writes("t1");

    clear();
    pq = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    ea = '{13'h0065, 13'h0066}; ed = '{8'hFF, 8'h0F};
    d0 = done_cnt;
    start_win(5, 2, 6, 1);
    feed(0);
    wait_done("t2", d0);
    check_writes("t2");

    clear();
    for (int i = 0; i < 16; i++) pq.push_back(2'd1);
    ea = '{13'h1FDF, 13'h1FB0, 13'h002F, 13'h0000};
    ed = '{8'h55, 8'h55, 8'h55, 8'h55};
    d0 = done_cnt;
    start_win(47, 169, 8, 2);
    feed(0);
    wait_done("t3", d0);
    check_writes("t3");

    for (int s = 0; s < 2; s++) begin
      clear();
      for (int i = 0; i < 64; i++) pq.push_back(2'(i % 4));
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          ea.push_back(13'((20 + r) * 48 + 10 + c));
          ed.push_back(8'hE4);
        end
      d0 = done_cnt;
      start_win(10, 20, 16, 4);
      feed(s == 1);
      wait_done(s == 1 ? "t4s" : "t4", d0);
      check_writes(s == 1 ? "t4s" : "t4");
    end

    clear();
    pix_valid = 1;
    x0 = xfer_cnt;
    d0 = done_cnt;
    start_win(0, 0, 0, 3);
    wait_done("t5", d0);
    pix_valid = 0;
    chk("t5_xfer", xfer_cnt, x0);
    chk("t5_nwr", wa.size(), 0);

    clear();
    pq = '{2'd2, 2'd2, 2'd2, 2'd2};
    ea = '{13'h0033}; ed = '{8'hAA};
    d0 = done_cnt;
    start_win(3, 1, 4, 1);
    x_start = 0; width_px = 8; start = 1;
    @(posedge clk); #1;
    start = 0;
    feed(0);
    wait_done("t5o", d0);
    check_writes("t5o");

    clear();
    pq = '{2'd1, 2'd1, 2'd1};
    start_win(0, 5, 8, 1);
    feed(0);
    d0 = done_cnt;
    #2 reset_n = 0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_we", vram_we, 0);
    chk("t6_rdy", pix_ready, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    chk("t6_nwr", wa.size(), 0);
    chk("t6_nodone", done_cnt, d0);
    clear();
    pq = '{2'd3, 2'd2, 2'd1, 2'd0};
    ea = '{13'h0002}; ed = '{8'h1B};
    d0 = done_cnt;
    start_win(2, 0, 4, 1);
    feed(0);
    wait_done("t6n", d0);
    check_writes("t6n");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
